// File: rtl/spi_shift_engine_pkg.sv
// Shared types and sizing helpers for the SPI shift engine.
// Holds the FSM state encoding and the SCK edge-counter width.
package spi_shift_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_STORE
    } state_t;

    // Bits needed to count the 2*WIDTH SCK edges of one word.
    function automatic int edge_cnt_w(input int width);
        return (2 * width > 1) ? $clog2(2 * width) : 1;
    endfunction

endpackage

// File: rtl/spi_shift_engine_clk_gen.sv
// SCK timebase: half-period down-counter, edge tick and leading/trailing flag.
// Latency: first tick clk_div+1 cycles after load, then every clk_div+1 cycles while run=1.
// Backpressure: none; the counter free-runs while run is high.
module spi_shift_engine_clk_gen #(
    parameter int CLKDIV_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load,
    input  logic                run,
    input  logic                shift,
    input  logic [CLKDIV_W-1:0] clk_div,
    output logic                tick,
    output logic                leading
);

    logic [CLKDIV_W-1:0] cnt;

    assign tick = run && (cnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            leading <= 1'b1;
        end else if (load) begin
            cnt     <= clk_div;
            leading <= 1'b1;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= clk_div;
                // Only SHIFT-phase ticks are real SCK edges; the SETUP tick is not.
                if (shift) leading <= ~leading;
            end else begin
                cnt <= cnt - CLKDIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master word engine between TX and RX FIFOs; optional LSB-first via SPI_LSB_FIRST_EN.
// Latency: 1 + (2*WIDTH+1)*(clk_div+1) + 1 cycles per word, one IDLE cycle between words.
// Backpressure: a word starts only when the RX FIFO has room, so rx_write never overflows it.
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CLKDIV_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    input  logic [CLKDIV_W-1:0] clk_div,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [WIDTH-1:0]    tx_data,
    input  logic                tx_exists,
    output logic                tx_read,
    output logic [WIDTH-1:0]    rx_data,
    output logic                rx_write,
    input  logic                rx_full,
    output logic                sck,
    output logic                mosi,
    input  logic                miso,
`ifdef SPI_LSB_FIRST_EN
    input  logic                lsb_first,
`endif
    output logic                busy
);

    localparam int             EW        = edge_cnt_w(WIDTH);
    localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * WIDTH - 1);

    state_t           state;
    logic             cpha_q;
    logic             lsb_q;
    logic             lsb_sel;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] rx_upd;
    logic [EW-1:0]    edge_cnt;
    logic             tick;
    logic             leading;
    logic             start;
    logic             sample_edge;
    logic             drive_edge;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_sel = lsb_first;
`else
    assign lsb_sel = 1'b0;
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] v, input logic lsb);
        return lsb ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] tx_next(input logic [WIDTH-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [WIDTH-1:0] rx_next(input logic [WIDTH-1:0] v, input logic b,
                                                 input logic lsb);
        return lsb ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
    endfunction

    assign start       = (state == ST_IDLE) && enable && tx_exists && !rx_full;
    assign sample_edge = tick && (state == ST_SHIFT) && (leading ^ cpha_q);
    // With cpha=0 the first bit went out at start, so the final trailing edge has nothing left to drive.
    assign drive_edge  = tick && (state == ST_SHIFT) && !(leading ^ cpha_q)
                         && !(!cpha_q && (edge_cnt == LAST_EDGE));
    assign rx_upd      = sample_edge ? rx_next(rx_sh, miso, lsb_q) : rx_sh;
    assign busy        = (state != ST_IDLE);

    spi_shift_engine_clk_gen #(
        .CLKDIV_W (CLKDIV_W)
    ) u_clk_gen (
        .clk     (clk),
        .rstn    (rstn),
        .load    (start),
        .run     ((state == ST_SETUP) || (state == ST_SHIFT)),
        .shift   (state == ST_SHIFT),
        .clk_div (clk_div),
        .tick    (tick),
        .leading (leading)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            tx_read  <= 1'b0;
            rx_write <= 1'b0;
            rx_data  <= '0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            edge_cnt <= '0;
        end else begin
            tx_read  <= 1'b0;
            rx_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sck <= cpol;
                    if (start) begin
                        tx_read  <= 1'b1;
                        cpha_q   <= cpha;
                        lsb_q    <= lsb_sel;
                        edge_cnt <= '0;
                        if (!cpha) begin
                            mosi  <= first_bit(tx_data, lsb_sel);
                            tx_sh <= tx_next(tx_data, lsb_sel);
                        end else begin
                            tx_sh <= tx_data;
                        end
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick) begin
                        sck      <= ~sck;
                        rx_sh    <= rx_upd;
                        edge_cnt <= edge_cnt + EW'(1);
                        if (drive_edge) begin
                            mosi  <= first_bit(tx_sh, lsb_q);
                            tx_sh <= tx_next(tx_sh, lsb_q);
                        end
                        // Push is registered here so rx_write is high during the STORE cycle itself.
                        if (edge_cnt == LAST_EDGE) begin
                            rx_data  <= rx_upd;
                            rx_write <= 1'b1;
                            state    <= ST_STORE;
                        end
                    end
                end
                ST_STORE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
